dot_prod_seq: RTL
=================

Name: dot_prod_seq

Overview:
Sequencer for the 4-element, 8-bit dot-product datapath (vector regfile, MAC, 16-bit accumulator with overflow).
- Tracks which A/B entries have been loaded.
- Auto-starts a computation when all entries are present, or on an explicit start.
- Steps the regfile read index, drives MAC-valid and accumulator-clear, then captures the result and overflow flag for the LED/7-seg path.
- Sits between the switch/button decode logic and the datapath.

Parameters:
N, 4, vector length (power of two)
IDX_W, 2, index width, log2(N)
ACC_W, 16, accumulator/result width
PIPE_LAT, 2, cycles from last mac_valid to a settled acc_in/ovf_in (product stage + acc stage)
AUTO_START, 1, 1 = start automatically when every A and B entry has been loaded

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset; synchronous, active-high (driven from debounced btnc)
wr_a  in  1  single-cycle strobe: A[wr_idx] written this cycle
wr_b  in  1  single-cycle strobe: B[wr_idx] written this cycle (may coincide with wr_a)
wr_idx  in  IDX_W  entry index for wr_a/wr_b
start  in  1  single-cycle start request
rd_idx  out  IDX_W  read index to the vector regfile
mac_valid  out  1  regfile outputs at rd_idx are to be accumulated this cycle
acc_clr  out  1  clear the accumulator this cycle
acc_in  in  ACC_W  accumulator value
ovf_in  in  1  accumulator sticky overflow
result  out  ACC_W  captured dot product
result_ovf  out  1  captured overflow
done  out  1  result valid and current
busy  out  1  high in CLEAR/ISSUE/DRAIN
loaded_a  out  N  per-entry loaded bitmap for A
loaded_b  out  N  per-entry loaded bitmap for B

Behaviour:
- Reset: state IDLE; all outputs 0; bitmaps 0; counters 0.
- Bitmaps: wr_a sets loaded_a[wr_idx]; wr_b sets loaded_b[wr_idx]. Bitmaps are cleared only by rst. Writes are accepted in every state.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE -> CLEAR when start=1, or when AUTO_START=1 and both bitmaps are all-ones (registered value).
- CLEAR: acc_clr=1 for exactly 1 cycle; cnt<=0; -> ISSUE.
- ISSUE: mac_valid=1 and rd_idx=cnt for N consecutive cycles, covering indices 0..N-1 in order; cnt==N-1 -> DRAIN.
- DRAIN: PIPE_LAT cycles with mac_valid=0. On exit, capture result<=acc_in and result_ovf<=ovf_in; done<=1; -> DONE.
- DONE: done held; result and result_ovf held. start -> CLEAR.
- Latency: last write sampled at edge E0 -> CLEAR after E1 -> ISSUE after E2 -> done=1 after edge E(N+PIPE_LAT+2), i.e. E8 at defaults.
- Write during CLEAR/ISSUE/DRAIN (abort):
  - -> IDLE; mac_valid=0; bitmap still updated; result unchanged; done=0.
  - With AUTO_START and full bitmaps, a fresh computation starts on the next cycle.
- Write during DONE: done<=0; -> IDLE. With full bitmaps the block recomputes automatically.
- start while busy: ignored.
- start and write together in IDLE: bitmap updates and start is honoured.
- Width rule: result = acc_in truncated to ACC_W; overflow is taken only from ovf_in.
- rst mid-operation: immediate return to reset state on the next edge.
- result and result_ovf keep their last values until the next capture or rst.

Optional Feature:
DOT_SEQ_SAT_EN
- Defined: at capture, if ovf_in=1 then result<= all-ones (0xFFFF); result_ovf still set.
- Undefined: the wrapped acc_in value is passed through unchanged.

Decomposition:
- Package dot_prod_pkg holds:
  - default N, IDX_W, ACC_W, PIPE_LAT;
  - FSM state encoding (3-bit localparams/enum);
  - the OFLO display constant used downstream.
- One sub-module, load_tracker: the two N-bit bitmaps plus the all-loaded flag.
- The FSM and counters stay in dot_prod_seq.

Test Plan:
- Load A=[1,2,3,4], B=[5,6,7,8] one strobe per cycle with a regfile/MAC model -> done rises 8 edges after the last strobe; result=0x0046; result_ovf=0; mac_valid high exactly 4 cycles with rd_idx 0,1,2,3.
- Load A=B=[255,255,0,0] via combined wr_a+wr_b strobes -> result=0xFC02, result_ovf=1. With DOT_SEQ_SAT_EN -> result=0xFFFF, result_ovf=1.
- In DONE from test 1, write B[3]=9 -> done drops next cycle, recompute starts automatically, result=0x004A.
- Write A[0] during ISSUE (cycle 2) -> mac_valid drops, done=0, restart; final result reflects the new A[0]; no double accumulation.
- Assert rst during DRAIN -> next cycle all outputs 0 and bitmaps cleared; no done until all 8 entries are reloaded.
- With only 3 A entries loaded, pulse start -> computation runs; start pulsed again while busy is ignored (exactly one acc_clr).

Source files
------------

// File: rtl/dot_prod_pkg.sv
// rtl/dot_prod_pkg.sv - shared defaults, FSM encoding and display constants for the dot-product sequencer
package dot_prod_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned IDX_W_DEF    = 2;
  localparam int unsigned ACC_W_DEF    = 16;
  localparam int unsigned PIPE_LAT_DEF = 2;

  // Glyph codes O,F,L,O shown on the 7-seg when the captured result overflowed
  localparam logic [15:0] OFLO_DISP = 16'h0F10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_CLEAR) || (s == ST_ISSUE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/load_tracker.sv
// rtl/load_tracker.sv - per-entry loaded bitmaps for vectors A and B plus all-loaded flag
module load_tracker
  import dot_prod_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_a,
  input  logic             wr_b,
  input  logic [IDX_W-1:0] wr_idx,
  output logic [N-1:0]     loaded_a,
  output logic [N-1:0]     loaded_b,
  output logic             all_loaded
);

  // Bits are sticky until reset; writes land in every sequencer state
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_a <= '0;
      loaded_b <= '0;
    end else begin
      if (wr_a) loaded_a[wr_idx] <= 1'b1;
      if (wr_b) loaded_b[wr_idx] <= 1'b1;
    end
  end

  // Derived from the registered bitmaps, so auto-start trails the last write by one edge
  assign all_loaded = (&loaded_a) & (&loaded_b);

endmodule

// File: rtl/dot_prod_seq.sv
// rtl/dot_prod_seq.sv - dot-product sequencer FSM; DOT_SEQ_SAT_EN saturates the captured result on overflow
module dot_prod_seq
  import dot_prod_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned PIPE_LAT   = PIPE_LAT_DEF,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_a,
  input  logic             wr_b,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             start,
  output logic [IDX_W-1:0] rd_idx,
  output logic             mac_valid,
  output logic             acc_clr,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             ovf_in,
  output logic [ACC_W-1:0] result,
  output logic             result_ovf,
  output logic             done,
  output logic             busy,
  output logic [N-1:0]     loaded_a,
  output logic [N-1:0]     loaded_b
);

  localparam int unsigned DRN_W = $clog2(PIPE_LAT + 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   cnt, cnt_n;
  logic [DRN_W-1:0]   dcnt, dcnt_n;
  logic [ACC_W-1:0]   result_n;
  logic               result_ovf_n;
  logic               all_loaded;
  logic               wr_any;
  logic               auto_go;

  load_tracker #(.N(N), .IDX_W(IDX_W)) u_load_tracker (
    .clk        (clk),
    .rst        (rst),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .wr_idx     (wr_idx),
    .loaded_a   (loaded_a),
    .loaded_b   (loaded_b),
    .all_loaded (all_loaded)
  );

  assign wr_any  = wr_a | wr_b;
  assign auto_go = AUTO_START && all_loaded;

  // Next state, counters and capture; any write aborts a run or invalidates a finished result
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    dcnt_n       = dcnt;
    result_n     = result;
    result_ovf_n = result_ovf;
    unique case (state)
      ST_IDLE: begin
        if (start || auto_go) begin
          state_n = ST_CLEAR;
          cnt_n   = '0;
        end
      end
      ST_CLEAR: begin
        if (wr_any) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_ISSUE;
          cnt_n   = '0;
        end
      end
      ST_ISSUE: begin
        if (wr_any) begin
          state_n = ST_IDLE;
        end else if (cnt == IDX_W'(N - 1)) begin
          state_n = ST_DRAIN;
          dcnt_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wr_any) begin
          state_n = ST_IDLE;
        end else if (dcnt == DRN_W'(PIPE_LAT - 1)) begin
          state_n      = ST_DONE;
          result_ovf_n = ovf_in;
`ifdef DOT_SEQ_SAT_EN
          result_n     = ovf_in ? {ACC_W{1'b1}} : acc_in;
`else
          result_n     = acc_in;
`endif
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (wr_any) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n = ST_CLEAR;
          cnt_n   = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered so they align with that state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dcnt       <= '0;
      rd_idx     <= '0;
      mac_valid  <= 1'b0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_ovf <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dcnt       <= dcnt_n;
      rd_idx     <= (state_n == ST_ISSUE) ? cnt_n : '0;
      mac_valid  <= (state_n == ST_ISSUE);
      acc_clr    <= (state_n == ST_CLEAR);
      busy       <= is_busy(state_n);
      done       <= (state_n == ST_DONE);
      result     <= result_n;
      result_ovf <= result_ovf_n;
    end
  end

endmodule
